// File: rtl/axil_reg_pkg.sv
// Shared constants, decode record and byte-strobe merge helper for the
// AXI-Lite register bank.
package axil_reg_pkg;

   // Word slots with dedicated meaning; everything from CFG_BASE up is RW.
   localparam int CTRL_IDX    = 0;
   localparam int ERR_IDX     = 1;
   localparam int CFG_BASE    = 2;

   // Bit positions inside the CTRL and ERR words.
   localparam int START_BIT   = 0;
   localparam int ERR_CLR_BIT = 0;

   // Width of the saturating out-of-range write counter.
   localparam int ERR_CNT_W   = 8;

   // Widest data word strb_merge can handle.
   localparam int MERGE_MAX_W    = 256;
   localparam int MERGE_MAX_STRB = MERGE_MAX_W / 8;

   // Decoded view of the request currently presented on the write port.
   typedef struct packed {
      logic oor;      // upper address bits nonzero
      logic is_ctrl;  // CTRL word (start trigger)
      logic is_err;   // ERR word (W1C of error state)
      logic is_cfg;   // one of the RW configuration words
   } wr_decode_t;

   // Replace every byte of old_word whose strobe is set with the matching
   // byte of data_word. Callers zero-extend narrower words to MERGE_MAX_W.
   function automatic logic [MERGE_MAX_W-1:0] strb_merge(
      input logic [MERGE_MAX_W-1:0]    old_word,
      input logic [MERGE_MAX_W-1:0]    data_word,
      input logic [MERGE_MAX_STRB-1:0] strb
   );
      logic [MERGE_MAX_W-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MERGE_MAX_STRB; b++) begin
         if (strb[b]) begin
            merged[b*8 +: 8] = data_word[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register bank behind the AXI-Lite write front end: decodes the word index,
// applies byte strobes to the RW configuration words, raises a one-cycle
// start pulse and keeps sticky/saturating out-of-range bookkeeping.
//
// Handshake: reg_wr_en is a level request held by upstream until it sees
// reg_wr_ack. A request commits on the first edge where reg_wr_en is high and
// ack_q is low; ack_q (= reg_wr_ack) is then high for exactly one cycle, and
// while it is high the still-asserted request is ignored, so each request
// commits exactly once. reg_wr_wait = reg_wr_en && !ack_q tells upstream the
// request has been seen and the ack is still pending.
module axil_reg_bank
   import axil_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 40,
   parameter int STRB_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ADDR_WIDTH-1:0]             reg_wr_addr,
   input  logic [DATA_WIDTH-1:0]             reg_wr_data,
   input  logic [STRB_WIDTH-1:0]             reg_wr_strb,
   input  logic                              reg_wr_en,
   output logic                              reg_wr_wait,
   output logic                              reg_wr_ack,
   output logic                              start,
   output logic [(DEPTH-2)*DATA_WIDTH-1:0]   cfg,
   output logic                              err_flag,
   output logic [7:0]                        err_count
);

   localparam int IDX_W   = $clog2(DEPTH);
   localparam int NUM_CFG = DEPTH - CFG_BASE;

   localparam logic [IDX_W-1:0] CTRL_SEL = IDX_W'(CTRL_IDX);
   localparam logic [IDX_W-1:0] ERR_SEL  = IDX_W'(ERR_IDX);
   localparam logic [IDX_W-1:0] CFG_SEL  = IDX_W'(CFG_BASE);

   logic                   ack_q;
   logic                   start_q;
   logic                   err_flag_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic [DATA_WIDTH-1:0]  cfg_q [NUM_CFG];

   logic                   commit;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       cfg_sel;
   wr_decode_t             dec;
   logic                   start_hit;
   logic                   err_clr_hit;

   logic [DATA_WIDTH-1:0]     old_word;
   logic [DATA_WIDTH-1:0]     merged_word;
   logic [MERGE_MAX_W-1:0]    old_wide;
   logic [MERGE_MAX_W-1:0]    data_wide;
   logic [MERGE_MAX_W-1:0]    merged_wide;
   logic [MERGE_MAX_STRB-1:0] strb_wide;

   // Byte-offset bits and the unused top of the merge result carry no meaning.
   logic                   unused_bits;
   assign unused_bits = ^{reg_wr_addr[1:0], merged_wide[MERGE_MAX_W-1:DATA_WIDTH]};

   // A request commits only while no ack is outstanding.
   assign commit      = reg_wr_en && !ack_q;
   assign reg_wr_wait = reg_wr_en && !ack_q;
   assign reg_wr_ack  = ack_q;
   assign start       = start_q;
   assign err_flag    = err_flag_q;
   assign err_count   = err_cnt_q;

   assign idx     = reg_wr_addr[IDX_W+1:2];
   assign cfg_sel = idx - CFG_SEL;

   // Classify the request: out-of-range wins over any index match.
   always_comb begin
      dec         = '0;
      dec.oor     = |reg_wr_addr[ADDR_WIDTH-1:IDX_W+2];
      if (!dec.oor) begin
         dec.is_ctrl = (idx == CTRL_SEL);
         dec.is_err  = (idx == ERR_SEL);
         dec.is_cfg  = (idx >= CFG_SEL);
      end
   end

   assign start_hit   = commit && dec.is_ctrl
                        && reg_wr_strb[START_BIT/8] && reg_wr_data[START_BIT];
   assign err_clr_hit = commit && dec.is_err
                        && reg_wr_strb[ERR_CLR_BIT/8] && reg_wr_data[ERR_CLR_BIT];

   // Read-modify-write path for the addressed RW word.
   assign old_word    = cfg_q[cfg_sel];
   assign old_wide    = MERGE_MAX_W'(old_word);
   assign data_wide   = MERGE_MAX_W'(reg_wr_data);
   assign strb_wide   = MERGE_MAX_STRB'(reg_wr_strb);
   assign merged_wide = strb_merge(old_wide, data_wide, strb_wide);
   assign merged_word = merged_wide[DATA_WIDTH-1:0];

   // Ack register: high for the single cycle after each commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= commit;
      end
   end

   // Self-clearing start pulse, aligned with the ack of the CTRL write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 1'b0;
      end else begin
         start_q <= start_hit;
      end
   end

   // Sticky error flag and saturating counter; out-of-range beats W1C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end else if (commit && dec.oor) begin
         err_flag_q <= 1'b1;
         if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end else if (err_clr_hit) begin
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end
   end

   // RW configuration words, byte-strobed update of the addressed slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CFG; i++) begin
            cfg_q[i] <= '0;
         end
      end else if (commit && dec.is_cfg) begin
         for (int i = 0; i < NUM_CFG; i++) begin
            if (cfg_sel == IDX_W'(i)) begin
               cfg_q[i] <= merged_word;
            end
         end
      end
   end

   // Flatten the RW words, lowest slot in the LSBs.
   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign cfg[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
   end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Self-checking bench for axil_reg_bank: table of single writes with
// hand-derived expectations, a scoreboard fed by a small reference model,
// and directed sequences for back-to-back, saturation and mid-write reset.
module tb_axil_reg_bank;

   localparam int DW    = 32;
   localparam int AW    = 40;
   localparam int SW    = 4;
   localparam int DEPTH = 16;
   localparam int NCFG  = DEPTH - 2;
   localparam int CFGW  = NCFG * DW;
   localparam int EXP_W = 1 + 1 + 8 + CFGW;

   logic              clk;
   logic              rst;
   logic [AW-1:0]     reg_wr_addr;
   logic [DW-1:0]     reg_wr_data;
   logic [SW-1:0]     reg_wr_strb;
   logic              reg_wr_en;
   logic              reg_wr_wait;
   logic              reg_wr_ack;
   logic              start;
   logic [CFGW-1:0]   cfg;
   logic              err_flag;
   logic [7:0]        err_count;

   axil_reg_bank #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .STRB_WIDTH (SW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .reg_wr_strb (reg_wr_strb),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_wait (reg_wr_wait),
      .reg_wr_ack  (reg_wr_ack),
      .start       (start),
      .cfg         (cfg),
      .err_flag    (err_flag),
      .err_count   (err_count)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // scoreboard: {start, err_flag, err_count, cfg} expected at the ack cycle
   logic [EXP_W-1:0] exp_q[$];

   // reference model state
   logic [DW-1:0] m_cfg [NCFG];
   logic          m_flag;
   logic [7:0]    m_cnt;

   // values captured from the DUT in the ack cycle of the last write
   logic          cap_start;
   logic          cap_flag;
   logic [7:0]    cap_cnt;
   logic [CFGW-1:0] cap_cfg;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      int            word_idx;
      logic [DW-1:0] exp_word;
      logic          exp_start;
      logic          exp_flag;
      logic [7:0]    exp_cnt;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
      m_flag = 1'b0;
      m_cnt  = '0;
   endtask

   function automatic logic [CFGW-1:0] model_cfg_flat();
      logic [CFGW-1:0] f;
      for (int i = 0; i < NCFG; i++) f[i*DW +: DW] = m_cfg[i];
      return f;
   endfunction

   // apply one committed write to the model and queue the expected result
   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      logic       oor;
      logic [3:0] idx;
      logic       st;
      oor = |a[AW-1:6];
      idx = a[5:2];
      st  = 1'b0;
      if (oor) begin
         m_flag = 1'b1;
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else if (idx == 4'd0) begin
         st = s[0] && d[0];
      end else if (idx == 4'd1) begin
         if (s[0] && d[0]) begin
            m_flag = 1'b0;
            m_cnt  = '0;
         end
      end else begin
         for (int b = 0; b < SW; b++)
            if (s[b]) m_cfg[idx-2][b*8 +: 8] = d[b*8 +: 8];
      end
      exp_q.push_back({st, m_flag, m_cnt, model_cfg_flat()});
   endtask

   // driver: present a request, hold it through the ack cycle, drop it after
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      int               n;
      logic             got;
      logic [EXP_W-1:0] e;
      @(negedge clk);
      reg_wr_addr = a;
      reg_wr_data = d;
      reg_wr_strb = s;
      reg_wr_en   = 1'b1;
      model_write(a, d, s);
      #1;
      check("wait_pending", reg_wr_wait, 1);
      got = 1'b0;
      n   = 0;
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         if (reg_wr_ack) got = 1'b1;
      end
      if (!got) begin
         check("ack_timeout", 0, 1);
         reg_wr_en = 1'b0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         return;
      end
      check("ack_latency", n, 1);
      cap_start = start;
      cap_flag  = err_flag;
      cap_cnt   = err_count;
      cap_cfg   = cfg;
      check("wait_in_ack", reg_wr_wait, 0);
      if (exp_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         check("sb_start", start, e[EXP_W-1]);
         check("sb_flag", err_flag, e[EXP_W-2]);
         check("sb_cnt", err_count, e[EXP_W-3 -: 8]);
         for (int i = 0; i < NCFG; i++)
            check($sformatf("sb_cfg%0d", i + 2), cfg[i*DW +: DW], e[i*DW +: DW]);
      end
      @(negedge clk);
      check("ack_one_cycle", reg_wr_ack, 0);
      check("start_one_cycle", start, 0);
      reg_wr_en = 1'b0;
   endtask

   task automatic apply_reset();
      reg_wr_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t vecs [15];

   initial begin
      rst         = 1'b1;
      reg_wr_en   = 1'b0;
      reg_wr_addr = '0;
      reg_wr_data = '0;
      reg_wr_strb = '0;
      model_reset();

      vecs[0]  = '{40'h8,          32'hDEADBEEF, 4'hF, 2,  32'hDEADBEEF, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{40'hC,          32'hAABBCCDD, 4'hF, 3,  32'hAABBCCDD, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{40'hC,          32'h11223344, 4'h5, 3,  32'hAA22CC44, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{40'h0,          32'h00000001, 4'h1, 2,  32'hDEADBEEF, 1'b1, 1'b0, 8'd0};
      vecs[4]  = '{40'h0,          32'h00000000, 4'hF, 2,  32'hDEADBEEF, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{40'h0,          32'h00000001, 4'h0, 3,  32'hAA22CC44, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{40'h1_0000_0040, 32'hFFFFFFFF, 4'hF, 2, 32'hDEADBEEF, 1'b0, 1'b1, 8'd1};
      vecs[7]  = '{40'h1_0000_0040, 32'hFFFFFFFF, 4'hF, 3, 32'hAA22CC44, 1'b0, 1'b1, 8'd2};
      vecs[8]  = '{40'h1_0000_0040, 32'hFFFFFFFF, 4'hF, 2, 32'hDEADBEEF, 1'b0, 1'b1, 8'd3};
      vecs[9]  = '{40'h4,          32'h00000000, 4'hF, 2,  32'hDEADBEEF, 1'b0, 1'b1, 8'd3};
      vecs[10] = '{40'h4,          32'h00000001, 4'h0, 2,  32'hDEADBEEF, 1'b0, 1'b1, 8'd3};
      vecs[11] = '{40'h4,          32'h00000001, 4'h1, 2,  32'hDEADBEEF, 1'b0, 1'b0, 8'd0};
      vecs[12] = '{40'h3F,         32'h12345678, 4'h8, 15, 32'h12000000, 1'b0, 1'b0, 8'd0};
      vecs[13] = '{40'h40,         32'h00000001, 4'h0, 15, 32'h12000000, 1'b0, 1'b1, 8'd1};
      vecs[14] = '{40'h4,          32'h00000001, 4'hF, 2,  32'hDEADBEEF, 1'b0, 1'b0, 8'd0};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ack", reg_wr_ack, 0);
      check("rst_wait", reg_wr_wait, 0);
      check("rst_start", start, 0);
      check("rst_flag", err_flag, 0);
      check("rst_cnt", err_count, 0);
      for (int i = 0; i < NCFG; i++) check($sformatf("rst_cfg%0d", i + 2), cfg[i*DW +: DW], 0);
      rst = 1'b0;
      @(negedge clk);

      // table-driven single writes
      for (int v = 0; v < 15; v++) begin
         do_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
         check($sformatf("vec%0d_word", v), cap_cfg[(vecs[v].word_idx-2)*DW +: DW], vecs[v].exp_word);
         check($sformatf("vec%0d_start", v), cap_start, vecs[v].exp_start);
         check($sformatf("vec%0d_flag", v), cap_flag, vecs[v].exp_flag);
         check($sformatf("vec%0d_cnt", v), cap_cnt, vecs[v].exp_cnt);
      end

      // back-to-back: request held 4 cycles commits twice (C and C+2)
      @(negedge clk);
      reg_wr_addr = 40'h1_0000_0040;
      reg_wr_data = '0;
      reg_wr_strb = 4'hF;
      reg_wr_en   = 1'b1;
      @(negedge clk); check("b2b_ack_c1", reg_wr_ack, 1);
      @(negedge clk); check("b2b_ack_c2", reg_wr_ack, 0);
      @(negedge clk); check("b2b_ack_c3", reg_wr_ack, 1);
      @(negedge clk); check("b2b_ack_c4", reg_wr_ack, 0);
      reg_wr_en = 1'b0;
      check("b2b_cnt", err_count, 2);
      check("b2b_flag", err_flag, 1);
      m_flag = 1'b1;
      m_cnt  = 8'd2;

      // saturation: 260 more out-of-range writes
      for (int k = 0; k < 260; k++)
         do_write({8'h01, 32'h0000_0000} | 40'($urandom_range(64, 255)), $urandom, 4'($urandom_range(0, 15)));
      check("sat_cnt", err_count, 255);
      check("sat_flag", err_flag, 1);
      check("sat_cfg2", cfg[31:0], 32'hDEADBEEF);

      // random in-range traffic checked by the scoreboard
      for (int k = 0; k < 40; k++)
         do_write(40'($urandom_range(8, 63)), $urandom, 4'($urandom_range(0, 15)));

      // reset asserted while a request is pending in cycle C
      @(negedge clk);
      reg_wr_addr = 40'h8;
      reg_wr_data = 32'h55555555;
      reg_wr_strb = 4'hF;
      reg_wr_en   = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ack", reg_wr_ack, 0);
      check("mid_rst_start", start, 0);
      check("mid_rst_flag", err_flag, 0);
      check("mid_rst_cnt", err_count, 0);
      for (int i = 0; i < NCFG; i++) check($sformatf("mid_rst_cfg%0d", i + 2), cfg[i*DW +: DW], 0);
      apply_reset();
      do_write(40'h10, 32'hCAFEF00D, 4'hF);
      check("post_rst_cfg4", cap_cfg[2*DW +: DW], 32'hCAFEF00D);
      do_write(40'h1_0000_0000, 32'h0, 4'h0);
      check("post_rst_cnt", cap_cnt, 1);
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

Register bank that consumes the register-write interface produced by the AXI-Lite write front end and turns it into configuration state for the accelerator. It decodes the word address and applies byte strobes to a bank of RW configuration words. It generates a self-clearing start pulse and tracks writes to out-of-range addresses. It drives `reg_wr_ack`/`reg_wr_wait` back upstream so each AXI-Lite write commits exactly once.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register/data width; must equal `8*STRB_WIDTH`.
- `ADDR_WIDTH`, 40: byte address width.
- `STRB_WIDTH`, 4: byte strobes.
- `DEPTH`, 16: number of word slots; power of 2, ≥4.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `reg_wr_addr` in ADDR_WIDTH: byte address.
- `reg_wr_data` in DATA_WIDTH: write data.
- `reg_wr_strb` in STRB_WIDTH: byte enables.
- `reg_wr_en` in 1: write request, level, held until acked.
- `reg_wr_wait` out 1: request seen, not yet acked.
- `reg_wr_ack` out 1: one-cycle commit acknowledge.
- `start` out 1: one-cycle start pulse.
- `cfg` out (DEPTH-2)*DATA_WIDTH: RW words, idx2 in LSBs.
- `err_flag` out 1: sticky out-of-range flag.
- `err_count` out 8: saturating out-of-range write count.

## Operation
- Word index `idx = reg_wr_addr[$clog2(DEPTH)+1:2]`; `addr[1:0]` ignored.
- A write is out-of-range if any bit of `reg_wr_addr[ADDR_WIDTH-1:$clog2(DEPTH)+2]` is nonzero.
- Commit condition: `reg_wr_en && !ack_q`.
- Exactly one commit per request, even though upstream holds `en` high through the ack cycle.
- Commit effects by target:
  - idx0 CTRL: if `strb[0] && data[0]`, `start` pulses next cycle. Nothing is stored.
  - idx1 ERR: if `strb[0] && data[0]`, `err_flag` and `err_count` clear (W1C). Other bits are ignored.
  - idx2..DEPTH-1 RW: byte `b` is updated iff `strb[b]`.
  - Out-of-range: no register changes. `err_flag` is set, and `err_count` increments, saturating at 255.
- An all-zero strobe still commits and acks, with no state change. The out-of-range bookkeeping still applies.
- Every commit is acked, including out-of-range ones. There is no error response.

## Timing
- Reset values: `reg_wr_ack`=0, `start`=0, `cfg`=0, `err_flag`=0, `err_count`=0. `reg_wr_wait`=0 because it is combinational and `en` is low.
- `reg_wr_wait = reg_wr_en && !ack_q`, combinational. It stalls the upstream timeout until the ack.
- Cycle C: `en`=1 and `ack_q`=0, so the write commits on the C edge.
- Cycle C+1: `ack_q`=1, `reg_wr_ack`=1, `start` pulses if triggered, and `cfg`/`err_*` show new values.
- If `en` is still high in C+1, it must not recommit. `ack_q` is a plain register set by commit, so it deasserts in C+2.
- Back-to-back requests:
  - If `en` is high in C+2, that is a new request and commits in C+2.
  - Minimum spacing is therefore 2 cycles per write.
- Saturation: `err_count`=255 plus another out-of-range write leaves the count at 255 and `err_flag` at 1.
- Reset mid-operation: all state clears asynchronously and the ack is lost.
  - Upstream relies on its own reset or timeout.
  - The first `en` after reset release commits normally.

## Structure
- Shared package `axil_reg_pkg`:
  - `CTRL_IDX`=0, `ERR_IDX`=1, `CFG_BASE`=2.
  - `START_BIT`=0, `ERR_CLR_BIT`=0, `ERR_CNT_W`=8.
  - A `strb_merge(old, data, strb)` function.
- Single flat module. No sub-module is needed.

## Test plan
- Reset, then write idx2 (addr 0x8) with data 0xDEADBEEF, strb 0xF, `en` held 2 cycles.
  - Required: `cfg[31:0]`=0xDEADBEEF at C+1.
  - Required: `ack` high for exactly 1 cycle, with a single commit.
- Write 0x11223344 strb 0x5 to idx3 when it holds 0xAABBCCDD.
  - Required: `cfg[63:32]`=0xAA22CC44.
- Write 0x1 to addr 0x0.
  - Required: `start` high for exactly 1 cycle at C+1, with no `cfg` change.
  - Then write 0x0 to addr 0x0: no pulse.
- Write to addr 0x1_0000_0040 three times.
  - Required: `err_flag`=1, `err_count`=3, `cfg` unchanged, each write acked.
  - Then write 0x1 to addr 0x4: both error fields clear.
- Issue 260 out-of-range writes.
  - Required: `err_count` saturates at 255.
- Assert `rst` while `en` is high in cycle C.
  - Required: all outputs go to 0 immediately.
  - After release, the next write commits once.
